// File: rtl/upool_row_assembler_if.sv
`default_nettype none
// ============================================================================
// Module : upool_row_assembler_if
// Brief  : Pixel-in / row-out handshake bundle for the unpool row assembler.
// Rev    : 1.0  initial release
// ============================================================================
interface upool_row_assembler_if #(
    parameter int BLK_W  = 4,
    parameter int OUT_W  = 32,
    parameter int RIDX_W = 5
);
    logic              pe_valid;
    logic              pe_ready;
    logic [BLK_W-1:0]  pe_data;
    logic              row_valid;
    logic              row_ready;
    logic [OUT_W-1:0]  row_data;
    logic [RIDX_W-1:0] row_idx;
    logic              frame_last;

    modport master (
        output pe_valid, pe_data, row_ready,
        input  pe_ready, row_valid, row_data, row_idx, frame_last
    );

    modport slave (
        input  pe_valid, pe_data, row_ready,
        output pe_ready, row_valid, row_data, row_idx, frame_last
    );
endinterface
`default_nettype wire

// File: rtl/upool_row_assembler.sv
`default_nettype none
// ============================================================================
// Module : upool_row_assembler
// Brief  : Gathers unpooled pixel blocks into POOL_H output rows, ping-pong
//          banked, and streams the rows out with row index and frame tracking.
// Rev    : 1.0  initial release
// ============================================================================
module upool_row_assembler #(
    parameter int POOL_H  = 2,
    parameter int POOL_W  = 2,
    parameter int IN_COLS = 16,
    parameter int IN_ROWS = 16
) (
    input wire                  clk,
    input wire                  rst_n,
    input wire                  clr,
    upool_row_assembler_if.slave bus
);
    localparam int BLK_W  = POOL_H * POOL_W;
    localparam int OUT_W  = IN_COLS * POOL_W;
    localparam int RIDX_W = (IN_ROWS * POOL_H > 1) ? $clog2(IN_ROWS * POOL_H) : 1;
    localparam int COL_W  = (IN_COLS > 1) ? $clog2(IN_COLS) : 1;
    localparam int SUB_W  = (POOL_H > 1) ? $clog2(POOL_H) : 1;
    localparam int ROW_W  = (IN_ROWS > 1) ? $clog2(IN_ROWS) : 1;

    logic [OUT_W-1:0] bank_q [2][POOL_H];
    logic [1:0]       full_q, full_d;
    logic             wr_bank_q, rd_bank_q;
    logic [COL_W-1:0] col_q;
    logic [SUB_W-1:0] sub_row_q;
    logic [ROW_W-1:0] in_row_q;

    logic accept, drain, fill_done, bank_release;

    // Fill and release can never target the same bank: fill needs it empty,
    // release needs it full. Both updates therefore compose freely.
    always_comb begin
        accept       = bus.pe_valid & ~full_q[wr_bank_q];
        drain        = full_q[rd_bank_q] & bus.row_ready;
        fill_done    = accept & (col_q == COL_W'(IN_COLS - 1));
        bank_release = drain & (sub_row_q == SUB_W'(POOL_H - 1));
        full_d       = full_q;
        if (fill_done)    full_d[wr_bank_q] = 1'b1;
        if (bank_release) full_d[rd_bank_q] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < POOL_H; r++)
                    bank_q[b][r] <= '0;
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            col_q     <= '0;
            sub_row_q <= '0;
            in_row_q  <= '0;
        end else if (clr) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            col_q     <= '0;
            sub_row_q <= '0;
            in_row_q  <= '0;
        end else begin
            full_q <= full_d;
            if (accept) begin
                for (int k = 0; k < IN_COLS; k++)
                    if (col_q == COL_W'(k))
                        for (int r = 0; r < POOL_H; r++)
                            bank_q[wr_bank_q][r][k*POOL_W +: POOL_W] <= bus.pe_data[r*POOL_W +: POOL_W];
                if (fill_done) begin
                    col_q     <= '0;
                    wr_bank_q <= ~wr_bank_q;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
            if (drain) begin
                if (bank_release) begin
                    sub_row_q <= '0;
                    rd_bank_q <= ~rd_bank_q;
                    if (in_row_q == ROW_W'(IN_ROWS - 1))
                        in_row_q <= '0;
                    else
                        in_row_q <= in_row_q + 1'b1;
                end else begin
                    sub_row_q <= sub_row_q + 1'b1;
                end
            end
        end
    end

    assign bus.pe_ready   = ~full_q[wr_bank_q];
    assign bus.row_valid  = full_q[rd_bank_q];
    assign bus.row_data   = bank_q[rd_bank_q][sub_row_q];
    assign bus.row_idx    = RIDX_W'(int'(in_row_q) * POOL_H + int'(sub_row_q));
    assign bus.frame_last = full_q[rd_bank_q]
                          & (in_row_q == ROW_W'(IN_ROWS - 1))
                          & (sub_row_q == SUB_W'(POOL_H - 1));
endmodule
`default_nettype wire

// File: tb/tb_upool_row_assembler.sv
`default_nettype none
// ============================================================================
// Module : tb_upool_row_assembler
// Brief  : Directed and random stimulus against a queue-based row model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_upool_row_assembler;
    localparam int POOL_H  = 2;
    localparam int POOL_W  = 2;
    localparam int IN_COLS = 4;
    localparam int IN_ROWS = 2;
    localparam int BLK_W   = POOL_H * POOL_W;
    localparam int OUT_W   = IN_COLS * POOL_W;
    localparam int RIDX_W  = 2;
    localparam int NROWS   = IN_ROWS * POOL_H;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clr   = 1'b0;
    always #5 clk = ~clk;

    upool_row_assembler_if #(.BLK_W(BLK_W), .OUT_W(OUT_W), .RIDX_W(RIDX_W)) bus ();

    upool_row_assembler #(
        .POOL_H(POOL_H), .POOL_W(POOL_W), .IN_COLS(IN_COLS), .IN_ROWS(IN_ROWS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", nm, $time);
    endtask

    // Model: pixels of the row being assembled, then finished output rows
    // waiting to be read; a bank stays occupied until all its rows are read.
    logic [BLK_W-1:0] m_part[$];
    logic [OUT_W-1:0] m_rows[$];
    int               m_out = 0;
    logic [OUT_W-1:0] m_rw;
    bit               m_acc, m_drn;

    function automatic int m_pending();
        return (m_rows.size() + POOL_H - 1) / POOL_H;
    endfunction
    function automatic bit m_ready();
        return m_pending() < 2;
    endfunction
    function automatic bit m_valid();
        return m_rows.size() > 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || clr) begin
            m_part.delete();
            m_rows.delete();
            m_out = 0;
        end else begin
            m_acc = bus.pe_valid && m_ready();
            m_drn = m_valid() && bus.row_ready;
            if (m_drn) begin
                void'(m_rows.pop_front());
                m_out++;
            end
            if (m_acc) begin
                m_part.push_back(bus.pe_data);
                if (m_part.size() == IN_COLS) begin
                    for (int r = 0; r < POOL_H; r++) begin
                        m_rw = '0;
                        for (int col = 0; col < IN_COLS; col++)
                            for (int c = 0; c < POOL_W; c++)
                                m_rw[col*POOL_W + c] = m_part[col][r*POOL_W + c];
                        m_rows.push_back(m_rw);
                    end
                    m_part.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("pe_ready", 64'(bus.pe_ready), 64'(m_ready()));
            chk("row_valid", 64'(bus.row_valid), 64'(m_valid()));
            if (m_valid()) begin
                chk("row_data", 64'(bus.row_data), 64'(m_rows[0]));
                chk("row_idx", 64'(bus.row_idx), 64'(m_out % NROWS));
                chk("frame_last", 64'(bus.frame_last), 64'((m_out % NROWS) == NROWS - 1));
            end else begin
                chk("frame_last_idle", 64'(bus.frame_last), 64'(0));
            end
        end
    end

    // Called just after a falling edge; returns just after the falling edge
    // that follows the accepting rising edge.
    task automatic send(input logic [BLK_W-1:0] d);
        int t = 0;
        bus.pe_valid = 1'b1;
        bus.pe_data  = d;
        while (!bus.pe_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) timeout("send");
        @(negedge clk);
        bus.pe_valid = 1'b0;
    endtask

    task automatic drain_all();
        int t = 0;
        bus.row_ready = 1'b1;
        while (bus.row_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) timeout("drain");
    endtask

    bit done = 1'b0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pe_valid  = 1'b0;
        bus.pe_data   = '0;
        bus.row_ready = 1'b0;
        #3;
        chk("rst_row_valid", 64'(bus.row_valid), 64'(0));
        chk("rst_pe_ready", 64'(bus.pe_ready), 64'(1));
        chk("rst_row_idx", 64'(bus.row_idx), 64'(0));
        chk("rst_frame_last", 64'(bus.frame_last), 64'(0));
        chk("rst_row_data", 64'(bus.row_data), 64'(0));
        #9 rst_n = 1'b1;
        @(negedge clk);

        // T1: one-hot blocks land on (row r, col*POOL_W+c)
        bus.row_ready = 1'b1;
        send(4'h1); send(4'h2); send(4'h4); send(4'h8);
        chk("t1_row0", 64'(bus.row_data), 64'h09);
        chk("t1_idx0", 64'(bus.row_idx), 64'd0);
        @(negedge clk);
        chk("t1_row1", 64'(bus.row_data), 64'h90);
        chk("t1_idx1", 64'(bus.row_idx), 64'd1);
        @(negedge clk);
        chk("t1_empty", 64'(bus.row_valid), 64'(0));

        // T2: consumer stalled, both banks fill, then a third row waits
        bus.row_ready = 1'b0;
        for (int i = 0; i < 2 * IN_COLS; i++) send(BLK_W'(i * 5 + 3));
        chk("t2_stall_ready", 64'(bus.pe_ready), 64'(0));
        repeat (5) @(negedge clk);
        chk("t2_hold_ready", 64'(bus.pe_ready), 64'(0));
        bus.row_ready = 1'b1;
        for (int i = 0; i < IN_COLS; i++) send(BLK_W'(i * 7 + 2));
        drain_all();

        // T3: last pixel of bank B accepted on the same edge bank A is released
        bus.row_ready = 1'b0;
        send(4'h6); send(4'h9); send(4'hA); send(4'h5);
        send(4'hF); send(4'h0); send(4'hF);
        bus.row_ready = 1'b1;
        @(negedge clk);
        bus.row_ready = 1'b0;
        @(negedge clk);
        bus.row_ready = 1'b1;
        bus.pe_valid  = 1'b1;
        bus.pe_data   = 4'h0;
        @(negedge clk);
        bus.pe_valid  = 1'b0;
        bus.row_ready = 1'b0;
        chk("t3_row_valid", 64'(bus.row_valid), 64'(1));
        chk("t3_pe_ready", 64'(bus.pe_ready), 64'(1));
        chk("t3_row_data", 64'(bus.row_data), 64'h33);
        for (int i = 0; i < 4; i++) begin
            bus.row_ready = ~bus.row_ready;
            @(negedge clk);
        end
        drain_all();

        // T5: flush mid-row with a bank full; T4: frame wrap afterwards
        bus.row_ready = 1'b0;
        for (int i = 0; i < IN_COLS + 2; i++) send(BLK_W'(i + 9));
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("t5_row_valid", 64'(bus.row_valid), 64'(0));
        chk("t5_pe_ready", 64'(bus.pe_ready), 64'(1));
        for (int i = 0; i < 2 * IN_COLS; i++) send(BLK_W'(i * 3 + 1));
        bus.row_ready = 1'b1;
        for (int k = 0; k < NROWS; k++) begin
            chk("t4_idx", 64'(bus.row_idx), 64'(k));
            chk("t4_last", 64'(bus.frame_last), 64'(k == NROWS - 1));
            @(negedge clk);
        end
        bus.row_ready = 1'b0;
        send(4'hC); send(4'h3); send(4'hE); send(4'h1);
        chk("t4_wrap_idx", 64'(bus.row_idx), 64'd0);
        chk("t4_wrap_last", 64'(bus.frame_last), 64'(0));
        drain_all();

        // T6: asynchronous reset pulse while rows are being drained
        bus.row_ready = 1'b0;
        for (int i = 0; i < IN_COLS + 2; i++) send(BLK_W'(15 - i));
        bus.row_ready = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_row_valid", 64'(bus.row_valid), 64'(0));
        chk("t6_pe_ready", 64'(bus.pe_ready), 64'(1));
        chk("t6_row_idx", 64'(bus.row_idx), 64'(0));
        chk("t6_frame_last", 64'(bus.frame_last), 64'(0));
        chk("t6_row_data", 64'(bus.row_data), 64'(0));
        #1 rst_n = 1'b1;
        @(negedge clk);
        bus.row_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    if ($urandom_range(2) == 0) @(negedge clk);
                    send(BLK_W'($urandom));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    bus.row_ready = 1'($urandom_range(1));
                    @(negedge clk);
                end
            end
        join
        drain_all();
        @(negedge clk);
        chk("end_row_valid", 64'(bus.row_valid), 64'(0));
        chk("end_pe_ready", 64'(bus.pe_ready), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
